// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags: commit writes, dispatch renames, roll flushes.
// Optional macro RF_COMMIT_BYPASS_EN forwards a matching in-flight commit onto the read ports.
module reg_file #(
  parameter int ROB_IDX_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic [4:0]           Dec_rs1,
  input  logic [4:0]           Dec_rs2,
  output logic                 Dec_busy1,
  output logic [ROB_IDX_W-1:0] Dec_tag1,
  output logic [XLEN-1:0]      Dec_val1,
  output logic                 Dec_busy2,
  output logic [ROB_IDX_W-1:0] Dec_tag2,
  output logic [XLEN-1:0]      Dec_val2,
  input  logic                 Dis_flag,
  input  logic [4:0]           Dis_rd,
  input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
  input  logic                 RF_write_flag,
  input  logic [4:0]           RF_rd,
  input  logic [ROB_IDX_W-1:0] RF_ROB_idx,
  input  logic [XLEN-1:0]      RF_val,
  input  logic                 ROB_roll
);

  localparam int PW = 1 + ROB_IDX_W + XLEN;

  logic [XLEN-1:0]      val_q [1:31];
  logic [ROB_IDX_W-1:0] tag_q [1:31];
  logic [31:1]          busy_q;

  // Packs {busy, tag, val} for one source index; x0 reads as a ready zero.
  function automatic logic [PW-1:0] read_port(input logic [4:0] rs);
    logic                 b;
    logic [ROB_IDX_W-1:0] t;
    logic [XLEN-1:0]      v;
    b = 1'b0;
    t = '0;
    v = '0;
    if (rs != 5'd0) begin
      v = val_q[rs];
      if (busy_q[rs]) begin
        b = 1'b1;
        t = tag_q[rs];
`ifdef RF_COMMIT_BYPASS_EN
        if (RF_write_flag && RF_rd == rs && tag_q[rs] == RF_ROB_idx && !ROB_roll) begin
          b = 1'b0;
          v = RF_val;
        end
`endif
      end
    end
    return {b, t, v};
  endfunction

  always_comb begin
    {Dec_busy1, Dec_tag1, Dec_val1} = read_port(Dec_rs1);
    {Dec_busy2, Dec_tag2, Dec_val2} = read_port(Dec_rs2);
  end

  // Ordering inside the update: roll clears, commit retires matching tag, rename wins last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 1; r < 32; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else if (rdy) begin
      if (ROB_roll)
        busy_q <= '0;
      if (RF_write_flag && RF_rd != 5'd0) begin
        val_q[RF_rd] <= RF_val;
        if (busy_q[RF_rd] && tag_q[RF_rd] == RF_ROB_idx)
          busy_q[RF_rd] <= 1'b0;
      end
      if (Dis_flag && Dis_rd != 5'd0 && !ROB_roll) begin
        busy_q[Dis_rd] <= 1'b1;
        tag_q[Dis_rd]  <= Dis_ROB_idx;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file against a per-register rename-table model.
module tb_reg_file;

  localparam int RW = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rdy;
  logic [4:0]    Dec_rs1, Dec_rs2;
  logic          Dec_busy1, Dec_busy2;
  logic [RW-1:0] Dec_tag1, Dec_tag2;
  logic [XL-1:0] Dec_val1, Dec_val2;
  logic          Dis_flag;
  logic [4:0]    Dis_rd;
  logic [RW-1:0] Dis_ROB_idx;
  logic          RF_write_flag;
  logic [4:0]    RF_rd;
  logic [RW-1:0] RF_ROB_idx;
  logic [XL-1:0] RF_val;
  logic          ROB_roll;

  reg_file #(.ROB_IDX_W(RW), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .Dec_rs1(Dec_rs1), .Dec_rs2(Dec_rs2),
    .Dec_busy1(Dec_busy1), .Dec_tag1(Dec_tag1), .Dec_val1(Dec_val1),
    .Dec_busy2(Dec_busy2), .Dec_tag2(Dec_tag2), .Dec_val2(Dec_val2),
    .Dis_flag(Dis_flag), .Dis_rd(Dis_rd), .Dis_ROB_idx(Dis_ROB_idx),
    .RF_write_flag(RF_write_flag), .RF_rd(RF_rd), .RF_ROB_idx(RF_ROB_idx),
    .RF_val(RF_val), .ROB_roll(ROB_roll)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference: architectural value plus "waiting on ROB entry" marker per register.
  logic [XL-1:0] m_val  [32];
  bit            m_busy [32];
  int            m_tag  [32];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = 0;
      end
    end else if (rdy) begin
      bit retire;
      retire = m_busy[RF_rd] && (m_tag[RF_rd] == int'(RF_ROB_idx));
      if (ROB_roll)
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      if (RF_write_flag && RF_rd != 0) begin
        m_val[RF_rd] = RF_val;
        if (retire) m_busy[RF_rd] = 1'b0;
      end
      if (Dis_flag && Dis_rd != 0 && !ROB_roll) begin
        m_busy[Dis_rd] = 1'b1;
        m_tag[Dis_rd]  = int'(Dis_ROB_idx);
      end
    end
  end

  function automatic void check_port(string p, int rs, logic b, logic [RW-1:0] t, logic [XL-1:0] v);
    bit eb;
    logic [XL-1:0] ev;
    eb = (rs != 0) && m_busy[rs];
    ev = (rs == 0) ? '0 : m_val[rs];
`ifdef RF_COMMIT_BYPASS_EN
    if (eb && RF_write_flag && RF_rd == rs && m_tag[rs] == int'(RF_ROB_idx) && !ROB_roll) begin
      eb = 1'b0;
      ev = RF_val;
    end
`endif
    chk({"busy", p}, 32'(b), 32'(eb));
    if (eb) chk({"tag", p}, 32'(t), m_tag[rs]);
    else    chk({"val", p}, v, ev);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check_port("1", int'(Dec_rs1), Dec_busy1, Dec_tag1, Dec_val1);
      check_port("2", int'(Dec_rs2), Dec_busy2, Dec_tag2, Dec_val2);
    end
  end

  task automatic idle();
    rdy = 1'b1; Dis_flag = 1'b0; Dis_rd = '0; Dis_ROB_idx = '0;
    RF_write_flag = 1'b0; RF_rd = '0; RF_ROB_idx = '0; RF_val = '0; ROB_roll = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(int rd, int tag);
    Dis_flag = 1'b1; Dis_rd = 5'(rd); Dis_ROB_idx = RW'(tag);
  endtask

  task automatic commit(int rd, int idx, logic [XL-1:0] v);
    RF_write_flag = 1'b1; RF_rd = 5'(rd); RF_ROB_idx = RW'(idx); RF_val = v;
  endtask

  initial begin
    idle();
    Dec_rs1 = 5'd5; Dec_rs2 = 5'd0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    step(); step();
    chk("rst_busy_x5", 32'(Dec_busy1), 0);
    chk("rst_val_x5", Dec_val1, 0);
    chk("rst_val_x0", Dec_val2, 0);
    rst_n = 1'b1;
    step();

    rename(0, 3); step(); idle();
    #1 chk("x0_busy", 32'(Dec_busy2), 0); chk("x0_val", Dec_val2, 0);

    rename(5, 2); step(); idle();
    #1 chk("x5_busy", 32'(Dec_busy1), 1); chk("x5_tag", 32'(Dec_tag1), 2);
    commit(5, 2, 32'h1234); step(); idle();
    #1 chk("x5_cbusy", 32'(Dec_busy1), 0); chk("x5_cval", Dec_val1, 32'h1234);

    Dec_rs1 = 5'd7;
    rename(7, 1); step(); rename(7, 4); step(); idle();
    commit(7, 1, 32'hAA); step(); idle();
    #1 chk("x7_busy", 32'(Dec_busy1), 1); chk("x7_tag", 32'(Dec_tag1), 4);
    commit(7, 4, 32'hBB); step(); idle();
    #1 chk("x7_cbusy", 32'(Dec_busy1), 0); chk("x7_cval", Dec_val1, 32'hBB);

    Dec_rs1 = 5'd9;
    commit(9, 3, 32'd7); rename(9, 6);
    #1 chk("x9_pre_busy", 32'(Dec_busy1), 0); chk("x9_pre_val", Dec_val1, 0);
    step(); idle();
    #1 chk("x9_busy", 32'(Dec_busy1), 1); chk("x9_tag", 32'(Dec_tag1), 6);

    rename(1, 5); step(); rename(2, 6); step(); idle();
    ROB_roll = 1'b1; commit(3, 0, 32'h100); rename(4, 7); step(); idle();
    Dec_rs1 = 5'd1; Dec_rs2 = 5'd2;
    #1 chk("roll_x1", 32'(Dec_busy1), 0); chk("roll_x2", 32'(Dec_busy2), 0);
    Dec_rs1 = 5'd4; Dec_rs2 = 5'd3;
    #1 chk("roll_x4", 32'(Dec_busy1), 0); chk("roll_x3", Dec_val2, 32'h100);

    Dec_rs1 = 5'd8;
    rename(8, 2); step(); idle();
    commit(8, 2, 32'h55);
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    chk("byp_busy", 32'(Dec_busy1), 0); chk("byp_val", Dec_val1, 32'h55);
`else
    chk("byp_busy", 32'(Dec_busy1), 1); chk("byp_tag", 32'(Dec_tag1), 2);
`endif
    step(); idle();
    #1 chk("x8_val", Dec_val1, 32'h55);

    Dec_rs1 = 5'd11;
    rdy = 1'b0; rename(11, 1); step(); idle();
    #1 chk("rdy_hold", 32'(Dec_busy1), 0);

    // Random traffic biased to a few registers so renames, commits and reads collide.
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      if (c == 1500) rst_n = 1'b0;
      if (c == 1504) rst_n = 1'b1;
      rdy = ($urandom_range(0, 9) != 0);
      ROB_roll = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        Dis_flag = 1'b1;
        Dis_rd = ($urandom_range(0, 4) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        Dis_ROB_idx = RW'($urandom);
      end
      if ($urandom_range(0, 9) < 5) begin
        r = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        RF_write_flag = 1'b1;
        RF_rd = 5'(r);
        RF_ROB_idx = (m_busy[r] && $urandom_range(0, 9) < 7) ? RW'(m_tag[r]) : RW'($urandom);
        RF_val = $urandom;
      end
      Dec_rs1 = ($urandom_range(0, 2) == 0) ? RF_rd : 5'($urandom_range(0, 9));
      Dec_rs2 = ($urandom_range(0, 2) == 0) ? Dis_rd : 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
